band_energy_window: RTL and testbench

Windowed band-power stage sitting directly downstream of the 12th-order band-pass IIR. It consumes the filter's signed 32-bit output samples, squares them and sums them over non-overlapping windows of `WIN_LEN` samples. Each finished window's energy is presented on a valid/ready output port for the feature/threshold logic that follows.

---
 rtl/band_energy_pkg.sv | 21 ++
 rtl/band_energy_window_square_stage.sv | 53 +++++
 rtl/band_energy_window.sv | 97 +++++++++
 tb/tb_band_energy_window.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/band_energy_pkg.sv
// Shared constants and helpers for the band-energy feature path.
package band_energy_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_WIN_LEN = 256;
  localparam int DEF_OUT_W   = 48;

  // Widest value the saturation helper can inspect.
  localparam int SAT_W = 128;

  // Accumulator width that can hold WIN_LEN full-scale squares without wrapping.
  function automatic int acc_width(input int data_w, input int win_len);
    return 2 * data_w + $clog2(win_len);
  endfunction

  // True when value can be represented in out_w unsigned bits.
  function automatic logic fits_width(input logic [SAT_W-1:0] value, input int unsigned out_w);
    return (value >> out_w) == '0;
  endfunction

endpackage

// File: rtl/band_energy_window_square_stage.sv
// Registered signed squarer: captures a sample, then produces its exact unsigned square.
module square_stage
  import band_energy_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  sample_valid,
  output logic [2*DATA_W-1:0]   sq,
  output logic                  sq_valid
);

  logic signed [DATA_W-1:0]   s1;
  logic                       s1_valid;
  logic signed [2*DATA_W-1:0] s1_ext;
  logic signed [2*DATA_W-1:0] prod;

  // Sign-extend before multiplying so the full-width product is exact, including (-2^(W-1))^2.
  always_comb begin
    s1_ext = (2*DATA_W)'(s1);
    prod   = s1_ext * s1_ext;
  end

  // Capture stage: hold the sample only when it is qualified; clear drops any sample on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1       <= '0;
      s1_valid <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) s1 <= signed'(sample_in);
    end
  end

  // Square stage: register the non-negative product as an unsigned value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq       <= '0;
      sq_valid <= 1'b0;
    end else if (clear) begin
      sq_valid <= 1'b0;
    end else begin
      sq_valid <= s1_valid;
      if (s1_valid) sq <= unsigned'(prod);
    end
  end

endmodule

// File: rtl/band_energy_window.sv
// Windowed band power: sums squared samples over non-overlapping windows and
// presents each window's (shifted, saturated) energy on a valid/ready port.
module band_energy_window
  import band_energy_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int SHIFT   = 0,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  localparam int ACC_W = acc_width(DATA_W, WIN_LEN);
  localparam int CNT_W = $clog2(WIN_LEN);

  logic [2*DATA_W-1:0] sq;
  logic                sq_valid;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    count;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    sum_shifted;
  logic [SAT_W-1:0]    sum_ext;
  logic [OUT_W-1:0]    sat_value;
  logic                last_sample;
  logic                win_done;

  square_stage #(.DATA_W(DATA_W)) u_square (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sq           (sq),
    .sq_valid     (sq_valid)
  );

  // Running sum including the square arriving this cycle, then shift and clamp for the output.
  always_comb begin
    sum         = acc + ACC_W'(sq);
    sum_shifted = sum >> SHIFT;
    sum_ext     = SAT_W'(sum_shifted);
    sat_value   = fits_width(sum_ext, OUT_W) ? sum_ext[OUT_W-1:0] : {OUT_W{1'b1}};
    last_sample = (count == CNT_W'(WIN_LEN - 1));
    win_done    = sq_valid && last_sample;
  end

  // Accumulator and sample counter; the final square restarts the window with no gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (sq_valid) begin
      if (last_sample) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= sum;
        count <= count + CNT_W'(1);
      end
    end
  end

  // Output register: load when free or being consumed, otherwise drop the result and flag overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (win_done) begin
      if (!out_valid || out_ready) begin
        out_data  <= sat_value;
        out_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_band_energy_window.sv
// Directed bench for band_energy_window with a result scoreboard.
module tb_band_energy_window;

  localparam int DATA_W  = 32;
  localparam int WIN_LEN = 4;
  localparam int OUT_W   = 48;

  logic              clk;
  logic              reset;
  logic              clear;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data, out_data16, out_data17;
  logic              out_valid, out_valid16, out_valid17;
  logic              overrun, overrun16, overrun17;

  int pass_count  = 0;
  int check_count = 0;
  logic [63:0] expq[$];

  band_energy_window #(.DATA_W(DATA_W), .WIN_LEN(WIN_LEN), .SHIFT(0), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .sample_in(sample_in), .sample_valid(sample_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun));

  band_energy_window #(.DATA_W(DATA_W), .WIN_LEN(WIN_LEN), .SHIFT(16), .OUT_W(OUT_W)) dut16 (
    .clk(clk), .reset(reset), .clear(clear), .sample_in(sample_in), .sample_valid(sample_valid),
    .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready), .overrun(overrun16));

  band_energy_window #(.DATA_W(DATA_W), .WIN_LEN(WIN_LEN), .SHIFT(17), .OUT_W(OUT_W)) dut17 (
    .clk(clk), .reset(reset), .clear(clear), .sample_in(sample_in), .sample_valid(sample_valid),
    .out_data(out_data17), .out_valid(out_valid17), .out_ready(out_ready), .overrun(overrun17));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  // Present one cycle of input, let the rising edge take it, then settle 1 time unit past the edge.
  task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data);
    sample_valid = valid;
    sample_in    = data;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0);
  endtask

  // Scoreboard: every accepted result must match the oldest expected window energy.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checkOutput("pending_result", (expq.size() != 0), 1'b1);
      if (expq.size() != 0) checkOutput("window_energy", 64'(out_data), expq.pop_front());
    end
  end

  initial begin
    reset = 1'b0; clear = 1'b0; sample_valid = 1'b0; sample_in = '0; out_ready = 1'b1;
    @(negedge clk);
    checkOutput("reset_out_data", 64'(out_data), 0);
    checkOutput("reset_out_valid", 64'(out_valid), 0);
    checkOutput("reset_overrun", 64'(overrun), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idleCycles(2);

    // Basic window with latency check.
    expq.push_back(64'd30);
    applyStimulus(1'b1, 32'd1);
    applyStimulus(1'b1, 32'd2);
    applyStimulus(1'b1, 32'd3);
    applyStimulus(1'b1, 32'd4);
    checkOutput("basic_valid_e0", 64'(out_valid), 0);
    idleCycles(1);
    checkOutput("basic_valid_e1", 64'(out_valid), 0);
    idleCycles(1);
    checkOutput("basic_valid_e2", 64'(out_valid), 1);
    checkOutput("basic_data_e2", 64'(out_data), 30);
    idleCycles(1);
    checkOutput("basic_valid_e3", 64'(out_valid), 0);

    // Negative samples then back-to-back window.
    expq.push_back(64'd36);
    expq.push_back(64'd100);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, -32'sd3);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd5);
    idleCycles(1);
    checkOutput("b2b_second_not_yet", 64'(out_valid), 0);
    idleCycles(1);
    checkOutput("b2b_second_valid", 64'(out_valid), 1);
    checkOutput("b2b_second_data", 64'(out_data), 100);
    idleCycles(3);

    // Saturation at three shift settings.
    expq.push_back((64'd1 << 48) - 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h8000_0000);
    idleCycles(2);
    checkOutput("sat_shift0", 64'(out_data), (64'd1 << 48) - 64'd1);
    checkOutput("sat_shift16", 64'(out_data16), (64'd1 << 48) - 64'd1);
    checkOutput("sat_shift17", 64'(out_data17), 64'd1 << 47);
    checkOutput("sat_shift17_valid", 64'(out_valid17), 1);
    idleCycles(3);

    // Backpressure: second window dropped, first held.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd2);
    idleCycles(4);
    checkOutput("bp_valid_held", 64'(out_valid), 1);
    checkOutput("bp_data_held", 64'(out_data), 4);
    checkOutput("bp_overrun", 64'(overrun), 1);
    expq.push_back(64'd4);
    out_ready = 1'b1;
    idleCycles(3);
    checkOutput("bp_drained", 64'(out_valid), 0);
    checkOutput("bp_overrun_sticky", 64'(overrun), 1);
    clear = 1'b1;
    idleCycles(1);
    clear = 1'b0;
    checkOutput("clear_overrun", 64'(overrun), 0);

    // Reset mid-window discards the partial sum.
    applyStimulus(1'b1, 32'd7);
    applyStimulus(1'b1, 32'd7);
    reset = 1'b0;
    #1;
    checkOutput("midreset_out_data", 64'(out_data), 0);
    checkOutput("midreset_out_valid", 64'(out_valid), 0);
    checkOutput("midreset_overrun", 64'(overrun), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    expq.push_back(64'd4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd1);
    idleCycles(4);

    // Clear coinciding with a valid sample drops that sample and the partial window.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd1);
    clear = 1'b1;
    applyStimulus(1'b1, 32'd1);
    clear = 1'b0;
    expq.push_back(64'd16);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd2);
    idleCycles(4);
    checkOutput("clear_case_overrun", 64'(overrun), 0);

    checkOutput("scoreboard_empty", 64'(expq.size()), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
